// File: rtl/minmax_tree.sv
// minmax_tree: pipelined N-channel min/max comparator tree
// with winner index and a peak-hold register on the result stream.
module minmax_tree #(
  parameter  int WIDTH  = 8,
  parameter  int N_CH   = 3,
  parameter  int SIGNED = 0,
  localparam int LVL    = $clog2(N_CH),
  localparam int IW     = (LVL < 1) ? 1 : LVL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  mode,
  input  logic [N_CH*WIDTH-1:0] din,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      dout,
  output logic [IW-1:0]         dout_idx,
  input  logic                  pk_clr,
  output logic                  pk_valid,
  output logic [WIDTH-1:0]      pk_val,
  output logic [IW-1:0]         pk_idx
);

  function automatic int ncnt(input int l);
    return (N_CH + (1 << l) - 1) >> l;
  endfunction

  function automatic logic lt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    if (SIGNED != 0) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Level 0 is the raw input; levels 1..LVL are registered.
  for (genvar l = 0; l <= LVL; l++) begin : lv
    localparam int CNT = ncnt(l);
    logic vld;
    logic md;

    for (genvar j = 0; j < CNT; j++) begin : nd
      logic [WIDTH-1:0] v;
      logic [IW-1:0]    i;

      if (l == 0) begin : g_src
        assign v = din[j*WIDTH +: WIDTH];
        assign i = IW'(j);
      end else if (2*j+1 < ncnt(l-1)) begin : g_cmp
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic [IW-1:0]    ai;
        logic [IW-1:0]    bi;
        logic             b_win;

        assign av = lv[l-1].nd[2*j].v;
        assign bv = lv[l-1].nd[2*j+1].v;
        assign ai = lv[l-1].nd[2*j].i;
        assign bi = lv[l-1].nd[2*j+1].i;
        // right node wins only when strictly better
        assign b_win = lv[l-1].md ? lt(av, bv)
                                  : lt(bv, av);

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v <= '0;
            i <= '0;
          end else if (lv[l-1].vld) begin
            v <= b_win ? bv : av;
            i <= b_win ? bi : ai;
          end
        end
      end else begin : g_pass
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v <= '0;
            i <= '0;
          end else if (lv[l-1].vld) begin
            v <= lv[l-1].nd[2*j].v;
            i <= lv[l-1].nd[2*j].i;
          end
        end
      end
    end

    if (l == 0) begin : g_vsrc
      assign vld = in_valid;
      assign md  = mode;
    end else begin : g_vreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          md  <= 1'b0;
        end else begin
          vld <= lv[l-1].vld;
          if (lv[l-1].vld) md <= lv[l-1].md;
        end
      end
    end
  end

  logic res_md;
  logic pk_better;

  assign out_valid = lv[LVL].vld;
  assign dout      = lv[LVL].nd[0].v;
  assign dout_idx  = lv[LVL].nd[0].i;
  assign res_md    = lv[LVL].md;
  assign pk_better = res_md ? lt(pk_val, dout)
                            : lt(dout, pk_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_valid <= 1'b0;
      pk_val   <= '0;
      pk_idx   <= '0;
    end else if (out_valid) begin
      pk_valid <= 1'b1;
      if (!pk_valid || pk_clr || pk_better) begin
        pk_val <= dout;
        pk_idx <= dout_idx;
      end
    end else if (pk_clr) begin
      pk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_minmax_tree.sv
// tb_minmax_tree: randomized and directed checks of minmax_tree
// against an in-bench scan model for several configurations.
module tb_minmax_tree;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic mode;
  logic pk_clr;
  logic [23:0] din3;
  logic [31:0] din4;
  logic [63:0] din8;

  logic ov3, pv3, ovs, pvs, ov4, pv4, ov8, pv8;
  logic [7:0] d3, pk3, ds, pks, d4, pk4, d8, pk8;
  logic [1:0] i3, pi3, is, pis, i4, pi4;
  logic [2:0] i8, pi8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  minmax_tree #(.WIDTH(8), .N_CH(3), .SIGNED(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .din(din3), .out_valid(ov3), .dout(d3), .dout_idx(i3),
    .pk_clr(pk_clr), .pk_valid(pv3), .pk_val(pk3), .pk_idx(pi3));

  minmax_tree #(.WIDTH(8), .N_CH(3), .SIGNED(1)) u3s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .din(din3), .out_valid(ovs), .dout(ds), .dout_idx(is),
    .pk_clr(pk_clr), .pk_valid(pvs), .pk_val(pks), .pk_idx(pis));

  minmax_tree #(.WIDTH(8), .N_CH(4), .SIGNED(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .din(din4), .out_valid(ov4), .dout(d4), .dout_idx(i4),
    .pk_clr(pk_clr), .pk_valid(pv4), .pk_val(pk4), .pk_idx(pi4));

  minmax_tree #(.WIDTH(8), .N_CH(8), .SIGNED(0)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .din(din8), .out_valid(ov8), .dout(d8), .dout_idx(i8),
    .pk_clr(pk_clr), .pk_valid(pv8), .pk_val(pk8), .pk_idx(pi8));

  function automatic int sval(input logic [7:0] x, input bit sgn);
    if (sgn) return int'($signed(x));
    return int'({24'd0, x});
  endfunction

  // Linear scan: first channel that is strictly better replaces.
  function automatic void ref_ext(
    input  logic [63:0] d,
    input  int          n,
    input  bit          sgn,
    input  bit          md,
    output logic [7:0]  v,
    output int          ix
  );
    logic [7:0] c;
    v  = d[7:0];
    ix = 0;
    for (int k = 1; k < n; k++) begin
      c = d[k*8 +: 8];
      if (md ? (sval(c, sgn) > sval(v, sgn))
             : (sval(c, sgn) < sval(v, sgn))) begin
        v  = c;
        ix = k;
      end
    end
  endfunction

  function automatic logic [7:0] rb();
    if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 3));
    return 8'($urandom);
  endfunction

  // One-cycle in_valid pulse; returns at the negedge where the
  // 2-level trees present their result.
  task automatic pulse(
    input logic [23:0] a3,
    input logic [31:0] a4,
    input logic [63:0] a8,
    input logic        md
  );
    @(negedge clk);
    din3 = a3; din4 = a4; din8 = a8;
    mode = md; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; pk_clr = 1'b0;
    din3 = '0; din4 = '0; din8 = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ov3, d3, i3, pv3, pk3, pi3} !== '0) begin
      n_fail++; $display("FAIL reset_u3 got %h exp 0", {ov3, d3, i3, pv3, pk3, pi3});
    end
    n_tests++;
    if ({ovs, ds, is, pvs, pks, pis} !== '0) begin
      n_fail++; $display("FAIL reset_u3s got %h exp 0", {ovs, ds, is, pvs, pks, pis});
    end
    n_tests++;
    if ({ov4, d4, i4, pv4, pk4, pi4} !== '0) begin
      n_fail++; $display("FAIL reset_u4 got %h exp 0", {ov4, d4, i4, pv4, pk4, pi4});
    end
    n_tests++;
    if ({ov8, d8, i8, pv8, pk8, pi8} !== '0) begin
      n_fail++; $display("FAIL reset_u8 got %h exp 0", {ov8, d8, i8, pv8, pk8, pi8});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_min3;
    logic [23:0] vec [3];
    logic [7:0]  ev  [3];
    logic [1:0]  ei  [3];
    vec[0] = {8'd35, 8'd15, 8'd10}; ev[0] = 8'd10; ei[0] = 2'd0;
    vec[1] = {8'd35, 8'd15, 8'd50}; ev[1] = 8'd15; ei[1] = 2'd1;
    vec[2] = {8'd35, 8'd44, 8'd50}; ev[2] = 8'd35; ei[2] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      pulse(vec[k], '0, '0, 1'b0);
      n_tests++;
      if (ov3 !== 1'b1 || d3 !== ev[k] || i3 !== ei[k]) begin
        n_fail++;
        $display("FAIL min3[%0d] got v=%0b d=%0d i=%0d exp v=1 d=%0d i=%0d",
                 k, ov3, d3, i3, ev[k], ei[k]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (ov3 !== 1'b0 || d3 !== 8'd35 || i3 !== 2'd2) begin
      n_fail++;
      $display("FAIL hold got v=%0b d=%0d i=%0d exp v=0 d=35 i=2", ov3, d3, i3);
    end
  endtask

  task automatic test_ties;
    pulse('0, {8'd3, 8'd9, 8'd9, 8'd7}, '0, 1'b1);
    n_tests++;
    if (ov4 !== 1'b1 || d4 !== 8'd9 || i4 !== 2'd1) begin
      n_fail++;
      $display("FAIL tie_max got v=%0b d=%0d i=%0d exp v=1 d=9 i=1", ov4, d4, i4);
    end
    pulse('0, {4{8'd4}}, '0, 1'b0);
    n_tests++;
    if (ov4 !== 1'b1 || d4 !== 8'd4 || i4 !== 2'd0) begin
      n_fail++;
      $display("FAIL tie_min got v=%0b d=%0d i=%0d exp v=1 d=4 i=0", ov4, d4, i4);
    end
  endtask

  task automatic test_signed;
    pulse({8'h7F, 8'hF0, 8'h05}, '0, '0, 1'b0);
    n_tests++;
    if (ovs !== 1'b1 || ds !== 8'hF0 || is !== 2'd1) begin
      n_fail++;
      $display("FAIL signed got v=%0b d=%h i=%0d exp v=1 d=f0 i=1", ovs, ds, is);
    end
    n_tests++;
    if (ov3 !== 1'b1 || d3 !== 8'h05 || i3 !== 2'd0) begin
      n_fail++;
      $display("FAIL unsigned got v=%0b d=%h i=%0d exp v=1 d=05 i=0", ov3, d3, i3);
    end
  endtask

  task automatic test_random;
    logic [23:0] a3;
    logic [31:0] a4;
    logic        md;
    logic [7:0]  ev;
    int          ei;
    for (int k = 0; k < 40; k++) begin
      a3 = {rb(), rb(), rb()};
      a4 = {rb(), rb(), rb(), rb()};
      md = 1'($urandom_range(0, 1));
      pulse(a3, a4, '0, md);
      ref_ext({40'd0, a3}, 3, 1'b0, md, ev, ei);
      n_tests++;
      if (ov3 !== 1'b1 || d3 !== ev || i3 !== 2'(ei)) begin
        n_fail++;
        $display("FAIL rand_u3[%0d] got d=%0d i=%0d exp d=%0d i=%0d", k, d3, i3, ev, ei);
      end
      ref_ext({40'd0, a3}, 3, 1'b1, md, ev, ei);
      n_tests++;
      if (ovs !== 1'b1 || ds !== ev || is !== 2'(ei)) begin
        n_fail++;
        $display("FAIL rand_u3s[%0d] got d=%0d i=%0d exp d=%0d i=%0d", k, ds, is, ev, ei);
      end
      ref_ext({32'd0, a4}, 4, 1'b0, md, ev, ei);
      n_tests++;
      if (ov4 !== 1'b1 || d4 !== ev || i4 !== 2'(ei)) begin
        n_fail++;
        $display("FAIL rand_u4[%0d] got d=%0d i=%0d exp d=%0d i=%0d", k, d4, i4, ev, ei);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ev [20];
    int         ei [20];
    logic [63:0] a8;
    logic        md;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      n_tests++;
      if (c >= 3 && c < 23) begin
        if (ov8 !== 1'b1 || d8 !== ev[c-3] || i8 !== 3'(ei[c-3])) begin
          n_fail++;
          $display("FAIL stream[%0d] got v=%0b d=%0d i=%0d exp v=1 d=%0d i=%0d",
                   c - 3, ov8, d8, i8, ev[c-3], ei[c-3]);
        end
      end else if (ov8 !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_idle[%0d] got v=%0b exp v=0", c, ov8);
      end
      if (c < 20) begin
        a8 = {rb(), rb(), rb(), rb(), rb(), rb(), rb(), rb()};
        md = 1'(c & 1);
        ref_ext(a8, 8, 1'b0, md, ev[c], ei[c]);
        din8 = a8; mode = md; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_peak;
    @(negedge clk);
    pk_clr = 1'b1;
    @(negedge clk);
    pk_clr = 1'b0;
    n_tests++;
    if (pv3 !== 1'b0) begin
      n_fail++; $display("FAIL pk_clr_idle got pv=%0b exp 0", pv3);
    end
    pulse({8'd60, 8'd50, 8'd20}, '0, '0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pv3 !== 1'b1 || pk3 !== 8'd20 || pi3 !== 2'd0) begin
      n_fail++;
      $display("FAIL pk_first got pv=%0b v=%0d i=%0d exp 1 20 0", pv3, pk3, pi3);
    end
    pulse({8'd40, 8'd12, 8'd60}, '0, '0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pv3 !== 1'b1 || pk3 !== 8'd12 || pi3 !== 2'd1) begin
      n_fail++;
      $display("FAIL pk_better got pv=%0b v=%0d i=%0d exp 1 12 1", pv3, pk3, pi3);
    end
    pulse({8'd12, 8'd50, 8'd40}, '0, '0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (pv3 !== 1'b1 || pk3 !== 8'd12 || pi3 !== 2'd1) begin
      n_fail++;
      $display("FAIL pk_equal got pv=%0b v=%0d i=%0d exp 1 12 1", pv3, pk3, pi3);
    end
    pulse({8'd50, 8'd40, 8'd30}, '0, '0, 1'b0);
    pk_clr = 1'b1;
    @(negedge clk);
    pk_clr = 1'b0;
    n_tests++;
    if (pv3 !== 1'b1 || pk3 !== 8'd30 || pi3 !== 2'd0) begin
      n_fail++;
      $display("FAIL pk_clr_load got pv=%0b v=%0d i=%0d exp 1 30 0", pv3, pk3, pi3);
    end
    pk_clr = 1'b1;
    @(negedge clk);
    pk_clr = 1'b0;
    n_tests++;
    if (pv3 !== 1'b0 || pk3 !== 8'd30 || pi3 !== 2'd0) begin
      n_fail++;
      $display("FAIL pk_clr_alone got pv=%0b v=%0d i=%0d exp 0 30 0", pv3, pk3, pi3);
    end
  endtask

  task automatic test_peak_random;
    logic [23:0] a3;
    logic        md;
    logic [7:0]  ev;
    int          ei;
    logic        m_vld;
    logic [7:0]  m_val;
    int          m_idx;
    m_vld = 1'b0; m_val = '0; m_idx = 0;
    for (int k = 0; k < 12; k++) begin
      a3 = {rb(), rb(), rb()};
      md = 1'($urandom_range(0, 1));
      pulse(a3, '0, '0, md);
      ref_ext({40'd0, a3}, 3, 1'b0, md, ev, ei);
      if (!m_vld || (md ? (ev > m_val) : (ev < m_val))) begin
        m_val = ev;
        m_idx = ei;
      end
      m_vld = 1'b1;
      @(negedge clk);
      n_tests++;
      if (pv3 !== m_vld || pk3 !== m_val || pi3 !== 2'(m_idx)) begin
        n_fail++;
        $display("FAIL pk_rand[%0d] got pv=%0b v=%0d i=%0d exp 1 %0d %0d",
                 k, pv3, pk3, pi3, m_val, m_idx);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] ev;
    int         ei;
    @(negedge clk);
    din3 = {8'd9, 8'd8, 8'd7}; din4 = '1; din8 = '1;
    mode = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ov3, d3, i3, pv3, pk3, pi3, ovs, ds, is, pvs, pks, pis} !== '0) begin
      n_fail++;
      $display("FAIL async_rst_u3 got %h exp 0",
               {ov3, d3, i3, pv3, pk3, pi3, ovs, ds, is, pvs, pks, pis});
    end
    n_tests++;
    if ({ov4, d4, i4, pv4, pk4, pi4, ov8, d8, i8, pv8, pk8, pi8} !== '0) begin
      n_fail++;
      $display("FAIL async_rst_u48 got %h exp 0",
               {ov4, d4, i4, pv4, pk4, pi4, ov8, d8, i8, pv8, pk8, pi8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({ov3, ovs, ov4, ov8} !== 4'b0) begin
        n_fail++;
        $display("FAIL post_rst[%0d] got valids=%b exp 0000", c, {ov3, ovs, ov4, ov8});
      end
    end
    pulse({8'd3, 8'd200, 8'd90}, '0, '0, 1'b1);
    ref_ext({40'd0, 24'({8'd3, 8'd200, 8'd90})}, 3, 1'b0, 1'b1, ev, ei);
    n_tests++;
    if (ov3 !== 1'b1 || d3 !== ev || i3 !== 2'(ei)) begin
      n_fail++;
      $display("FAIL post_rst_new got v=%0b d=%0d i=%0d exp 1 %0d %0d", ov3, d3, i3, ev, ei);
    end
  endtask

  initial begin
    test_reset();
    test_min3();
    test_ties();
    test_signed();
    test_random();
    test_back_to_back();
    test_peak();
    test_peak_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
